dcache_mem_arbiter: RTL and testbench

DCACHE_MEM_ARBITER -- requirements
Module: dcache_mem_arbiter

---
 rtl/lsu_arb_pkg.sv | 19 +
 rtl/rd_id_fifo.sv | 51 +++++
 rtl/dcache_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dcache_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// rtl/lsu_arb_pkg.sv - shared types and defaults for the dcache memory arbiter
package lsu_arb_pkg;

  // Requester identities, also stored in the read-response ID FIFO
  typedef enum logic [1:0] {
    REQ_WB = 2'd0,
    REQ_RF = 2'd1,
    REQ_UC = 2'd2
  } req_id_t;

  // Arbiter FSM: IDLE has no grant, HOLD presents the latched request
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  localparam int STARVE_LIMIT_DEF = 15;

endpackage

// File: rtl/rd_id_fifo.sv
// rtl/rd_id_fifo.sv - in-order FIFO of requester IDs for outstanding reads
module rd_id_fifo
  import lsu_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [1:0]    push_id,
  input  logic          pop,
  output logic [1:0]    head_id,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [1:0]    slots [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop in the same cycle frees the slot, so a push is allowed even when full
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = slots[rd_ptr];

  // ID storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dcache_mem_arbiter.sv
// rtl/dcache_mem_arbiter.sv - arbitrates writeback, refill and uncached requests onto one memory port
module dcache_mem_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [31:0]  wb_addr,
  input  logic [127:0] wb_data,
  input  logic         rf_valid,
  output logic         rf_ready,
  input  logic [27:0]  rf_addr,
  input  logic         uc_valid,
  output logic         uc_ready,
  input  logic         uc_wen,
  input  logic [31:0]  uc_addr,
  input  logic [31:0]  uc_data,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic         mem_wen,
  output logic         mem_uncached,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_data,
  input  logic         mem_rvalid,
  output logic         mem_rready,
  input  logic [127:0] mem_rdata,
  output logic         rf_rvalid,
  output logic [127:0] rf_rdata,
  output logic         uc_rvalid,
  output logic [31:0]  uc_rdata,
  output logic         err
);

  localparam int CW = $clog2(OUTSTANDING) + 1;

  arb_state_t    state;
  arb_state_t    state_nx;
  req_id_t       gnt;
  req_id_t       win_id;
  logic          win_any;
  logic [3:0]    starve;
  logic [CW-1:0] rd_count;
  logic [1:0]    head_id;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          rd_block;
  logic          rf_elig;
  logic          uc_elig;
  logic          uc_promo;

  assign pop        = mem_rvalid & ~fifo_empty;
  assign push       = mem_valid & mem_ready & ~mem_wen & (~fifo_full | pop);
  assign mem_rready = ~fifo_empty;

  // A response retiring this cycle frees a slot for a read granted in the same cycle
  assign rd_block = (rd_count == CW'(OUTSTANDING)) & ~pop;
  // Refill must wait for a pending writeback of the same line
  assign rf_elig  = rf_valid & ~rd_block & ~(wb_valid & (wb_addr[31:4] == rf_addr));
  assign uc_elig  = uc_valid & (uc_wen | ~rd_block);
  assign uc_promo = uc_elig & (starve == 4'(STARVE_LIMIT));

  // Fixed priority wb > rf > uc, overridden by a starved uc requester
  always_comb begin
    win_any = 1'b1;
    win_id  = REQ_WB;
    if (uc_promo)      win_id = REQ_UC;
    else if (wb_valid) win_id = REQ_WB;
    else if (rf_elig)  win_id = REQ_RF;
    else if (uc_elig)  win_id = REQ_UC;
    else               win_any = 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // FSM next state and handshake outputs; readies only while the grant is held
  always_comb begin
    state_nx  = state;
    mem_valid = 1'b0;
    wb_ready  = 1'b0;
    rf_ready  = 1'b0;
    uc_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_any) state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        mem_valid = 1'b1;
        wb_ready  = mem_ready & (gnt == REQ_WB);
        rf_ready  = mem_ready & (gnt == REQ_RF);
        uc_ready  = mem_ready & (gnt == REQ_UC);
        if (mem_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Latch the winning request in IDLE; it stays frozen throughout HOLD
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt          <= REQ_WB;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_wen      <= 1'b0;
      mem_uncached <= 1'b0;
    end else if (state == ST_IDLE && win_any) begin
      gnt <= win_id;
      case (win_id)
        REQ_WB: begin
          mem_addr     <= wb_addr;
          mem_data     <= wb_data;
          mem_wen      <= 1'b1;
          mem_uncached <= 1'b0;
        end
        REQ_RF: begin
          mem_addr     <= {rf_addr, 4'b0};
          mem_data     <= '0;
          mem_wen      <= 1'b0;
          mem_uncached <= 1'b0;
        end
        default: begin
          mem_addr     <= uc_addr;
          mem_data     <= {96'b0, uc_data};
          mem_wen      <= uc_wen;
          mem_uncached <= 1'b1;
        end
      endcase
    end
  end

  // Count IDLE cycles in which uc waits while another requester is granted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve <= '0;
    end else if (state == ST_IDLE && win_any) begin
      if (win_id == REQ_UC)
        starve <= '0;
      else if (uc_valid && starve != 4'(STARVE_LIMIT))
        starve <= starve + 4'd1;
    end
  end

  // Sticky error on a response nobody asked for
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      err <= 1'b0;
    else if (mem_rvalid & fifo_empty) err <= 1'b1;
  end

  assign rf_rvalid = pop & (head_id == REQ_RF);
  assign uc_rvalid = pop & (head_id == REQ_UC);
  assign rf_rdata  = mem_rdata;
  assign uc_rdata  = mem_rdata[31:0];

  rd_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_rd_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .push_id (gnt),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rd_count)
  );

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// tb/tb_dcache_mem_arbiter.sv - self-checking bench for dcache_mem_arbiter
module tb_dcache_mem_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         wb_valid, wb_ready;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         rf_valid, rf_ready;
  logic [27:0]  rf_addr;
  logic         uc_valid, uc_ready, uc_wen;
  logic [31:0]  uc_addr, uc_data;
  logic         mem_valid, mem_ready, mem_wen, mem_uncached;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic         mem_rvalid, mem_rready;
  logic [127:0] mem_rdata;
  logic         rf_rvalid, uc_rvalid;
  logic [127:0] rf_rdata;
  logic [31:0]  uc_rdata;
  logic         err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_mem_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(15)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr),
    .uc_valid(uc_valid), .uc_ready(uc_ready), .uc_wen(uc_wen), .uc_addr(uc_addr), .uc_data(uc_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_uncached(mem_uncached),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .rf_rvalid(rf_rvalid), .rf_rdata(rf_rdata), .uc_rvalid(uc_rvalid), .uc_rdata(uc_rdata),
    .err(err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    rf_valid = 0; rf_addr = '0;
    uc_valid = 0; uc_wen = 0; uc_addr = '0; uc_data = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    resetn = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits up to budget cycles for a memory handshake; id stays 0 if no handshake occurs
  task automatic wait_hs(input int budget, output int id, output logic [31:0] addr);
    id = 0;
    addr = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_valid && mem_ready) begin
        id = wb_ready ? 1 : rf_ready ? 2 : uc_ready ? 3 : 9;
        addr = mem_addr;
        step();
        return;
      end
      step();
    end
  endtask

  typedef struct {
    logic wb;
    logic rf;
    logic uc;
    logic wen;
    int   exp;   // 0 none, 1 wb, 2 rf, 3 uc
  } vec_t;

  vec_t vt [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int id;
    int rf_cnt;
    logic uc_seen;
    logic [31:0] a;
    logic [31:0] exp_addr;
    logic [127:0] d0, d1;
    int q[$];
    int hs_n, uc_n;
    logic stall_prev;
    logic [31:0] addr_prev;
    logic wb_hs, rf_hs, uc_hs;

    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 3};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 3};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 2};
    vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
    vt[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1};

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_readies", {wb_ready, rf_ready, uc_ready}, 0);
    chk("rst_rready", mem_rready, 0);
    chk("rst_err", err, 0);
    chk("rst_rvalids", {rf_rvalid, uc_rvalid}, 0);

    // single-grant arbitration vectors from IDLE
    for (int i = 0; i < 9; i++) begin
      do_reset();
      wb_valid = vt[i].wb; wb_addr = 32'h0000_1000; wb_data = 128'h11112222_33334444_55556666_77778888;
      rf_valid = vt[i].rf; rf_addr = 28'h0000200;
      uc_valid = vt[i].uc; uc_wen = vt[i].wen; uc_addr = 32'h0000_3004; uc_data = 32'hCAFE_0001;
      step();
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), mem_valid, vt[i].exp != 0);
      chk($sformatf("vec%0d_readies", i), {wb_ready, rf_ready, uc_ready}, 0);
      if (vt[i].exp != 0) begin
        exp_addr = (vt[i].exp == 1) ? 32'h0000_1000 : (vt[i].exp == 2) ? 32'h0000_2000 : 32'h0000_3004;
        chk($sformatf("vec%0d_addr", i), mem_addr, exp_addr);
        chk($sformatf("vec%0d_wen", i), mem_wen, (vt[i].exp == 1) || (vt[i].exp == 3 && vt[i].wen));
        chk($sformatf("vec%0d_unc", i), mem_uncached, vt[i].exp == 3);
        if (vt[i].exp == 3)
          chk($sformatf("vec%0d_data", i), mem_data, 128'hCAFE_0001);
      end
    end

    // wb and rf on different lines: wb first, rf on the next IDLE
    do_reset();
    mem_ready = 1;
    wb_valid = 1; wb_addr = 32'h0000_1000;
    rf_valid = 1; rf_addr = 28'h0000200;
    wait_hs(2, id, a);
    chk("order_first_wb", id, 1);
    wb_valid = 0;
    wait_hs(2, id, a);
    chk("order_then_rf", id, 2);
    chk("order_rf_addr", a, 32'h0000_2000);

    // same line: rf waits for wb, request stable while memory stalls
    do_reset();
    wb_valid = 1; wb_addr = 32'h0000_1230; wb_data = 128'hABCD;
    rf_valid = 1; rf_addr = 28'h0000123;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), mem_valid, 1);
      chk($sformatf("stall%0d_addr", i), mem_addr, 32'h0000_1230);
      chk($sformatf("stall%0d_rf_ready", i), rf_ready, 0);
      step();
    end
    mem_ready = 1;
    wait_hs(1, id, a);
    chk("same_line_wb", id, 1);
    wb_valid = 0;
    wait_hs(2, id, a);
    chk("same_line_rf", id, 2);
    chk("same_line_rf_addr", a, 32'h0000_1230);

    // outstanding limit: 4 reads, 5th blocked, writes still go, pop frees a slot
    do_reset();
    mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      rf_valid = 1; rf_addr = 28'(k + 16);
      wait_hs(2, id, a);
      chk($sformatf("fill%0d", k), id, 2);
      rf_valid = 0;
    end
    rf_valid = 1; rf_addr = 28'h0000050;
    wb_valid = 1; wb_addr = 32'h0000_5000;
    wait_hs(3, id, a);
    chk("full_wb_granted", id, 1);
    wb_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("full_rf_blocked%0d", i), mem_valid, 0);
      step();
    end
    mem_rvalid = 1; mem_rdata = 128'h5A5A;
    @(negedge clk);
    chk("full_pop_rvalid", rf_rvalid, 1);
    chk("full_pop_rdata", rf_rdata, 128'h5A5A);
    step();
    mem_rvalid = 0;
    @(negedge clk);
    chk("full_new_read_valid", mem_valid, 1);
    chk("full_new_read_addr", mem_addr, 32'h0000_0500);
    chk("full_new_read_ready", rf_ready, 1);
    step();
    rf_valid = 0;
    @(negedge clk);
    chk("full_still_pending", mem_rready, 1);

    // in-order routing: rf response then uc response
    do_reset();
    mem_ready = 1;
    rf_valid = 1; rf_addr = 28'h0000077;
    wait_hs(2, id, a);
    chk("route_rf_hs", id, 2);
    rf_valid = 0;
    uc_valid = 1; uc_wen = 0; uc_addr = 32'h4000_0010;
    wait_hs(2, id, a);
    chk("route_uc_hs", id, 3);
    uc_valid = 0;
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    mem_rvalid = 1; mem_rdata = d0;
    @(negedge clk);
    chk("route_d0_rf_rvalid", rf_rvalid, 1);
    chk("route_d0_uc_rvalid", uc_rvalid, 0);
    chk("route_d0_data", rf_rdata, d0);
    step();
    mem_rdata = d1;
    @(negedge clk);
    chk("route_d1_uc_rvalid", uc_rvalid, 1);
    chk("route_d1_rf_rvalid", rf_rvalid, 0);
    chk("route_d1_data", uc_rdata, d1[31:0]);
    step();
    mem_rvalid = 0;
    @(negedge clk);
    chk("route_drained", mem_rready, 0);

    // starvation: uc promoted after 15 lost cycles against continuous rf
    do_reset();
    mem_ready = 1;
    rf_valid = 1; rf_addr = 28'h0000099;
    uc_valid = 1; uc_wen = 1; uc_addr = 32'h0000_0040; uc_data = 32'h1;
    rf_cnt = 0;
    uc_seen = 0;
    for (int i = 0; i < 80 && !uc_seen; i++) begin
      mem_rvalid = mem_rready; mem_rdata = 128'($urandom);
      @(negedge clk);
      if (mem_valid && mem_ready && rf_ready) rf_cnt++;
      if (mem_valid && mem_ready && uc_ready) uc_seen = 1;
      step();
    end
    chk("starve_uc_granted", uc_seen, 1);
    chk("starve_lost_cycles", rf_cnt, 15);
    rf_valid = 0; uc_valid = 0;
    repeat (4) begin
      mem_rvalid = mem_rready;
      step();
    end
    mem_rvalid = 0;
    @(negedge clk);
    chk("err_clear_before", err, 0);
    step();
    mem_rvalid = 1; mem_rdata = 128'hDEAD;
    @(negedge clk);
    chk("err_dropped", {rf_rvalid, uc_rvalid}, 0);
    step();
    mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("err_sticky%0d", i), err, 1);
      step();
    end
    do_reset();
    @(negedge clk);
    chk("err_reset", err, 0);

    // reset during HOLD abandons the request
    do_reset();
    wb_valid = 1; wb_addr = 32'h0000_7000;
    step();
    @(negedge clk);
    chk("midhold_valid", mem_valid, 1);
    mem_ready = 1;
    #1 chk("midhold_ready", wb_ready, 1);
    #1 resetn = 0;
    #1 chk("midhold_abandon_valid", mem_valid, 0);
    chk("midhold_abandon_ready", wb_ready, 0);
    do_reset();

    // randomized traffic against a transaction-level scoreboard
    hs_n = 0;
    uc_n = 0;
    stall_prev = 0;
    addr_prev = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!wb_valid && $urandom_range(0, 3) == 0) begin
        wb_valid = 1;
        wb_addr = $urandom & 32'hFFFF_FFF0;
        wb_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!rf_valid && $urandom_range(0, 2) == 0) begin
        rf_valid = 1;
        rf_addr = ($urandom_range(0, 3) == 0) ? wb_addr[31:4] : 28'($urandom);
      end
      if (!uc_valid && $urandom_range(0, 3) == 0) begin
        uc_valid = 1;
        uc_wen = 1'($urandom);
        uc_addr = $urandom;
        uc_data = $urandom;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rvalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("rnd_rready", mem_rready, q.size() > 0);
      if (stall_prev) begin
        chk("rnd_hold_valid", mem_valid, 1);
        chk("rnd_hold_addr", mem_addr, addr_prev);
      end
      if (mem_rvalid) begin
        id = q.pop_front();
        chk("rnd_rf_rvalid", rf_rvalid, id == 2);
        chk("rnd_uc_rvalid", uc_rvalid, id == 3);
        if (id == 2) chk("rnd_rf_rdata", rf_rdata, mem_rdata);
        else         chk("rnd_uc_rdata", uc_rdata, mem_rdata[31:0]);
      end else begin
        chk("rnd_no_rvalid", {rf_rvalid, uc_rvalid}, 0);
      end
      wb_hs = mem_valid & mem_ready & wb_ready;
      rf_hs = mem_valid & mem_ready & rf_ready;
      uc_hs = mem_valid & mem_ready & uc_ready;
      if (mem_valid && mem_ready) begin
        hs_n++;
        chk("rnd_one_ready", int'(wb_ready) + int'(rf_ready) + int'(uc_ready), 1);
        if (wb_ready) begin
          chk("rnd_wb_addr", mem_addr, wb_addr);
          chk("rnd_wb_data", mem_data, wb_data);
          chk("rnd_wb_flags", {mem_wen, mem_uncached}, 2'b10);
        end else if (rf_ready) begin
          chk("rnd_rf_addr", mem_addr, {rf_addr, 4'h0});
          chk("rnd_rf_flags", {mem_wen, mem_uncached}, 2'b00);
          q.push_back(2);
        end else if (uc_ready) begin
          uc_n++;
          chk("rnd_uc_addr", mem_addr, uc_addr);
          chk("rnd_uc_data", mem_data, {96'b0, uc_data});
          chk("rnd_uc_flags", {mem_wen, mem_uncached}, {uc_wen, 1'b1});
          if (!uc_wen) q.push_back(3);
        end
        chk("rnd_depth", q.size() <= 4, 1);
      end else begin
        chk("rnd_no_ready", {wb_ready, rf_ready, uc_ready}, 0);
      end
      stall_prev = mem_valid & ~mem_ready;
      addr_prev = mem_addr;
      step();
      if (wb_hs) wb_valid = 0;
      if (rf_hs) rf_valid = 0;
      if (uc_hs) uc_valid = 0;
    end
    chk("rnd_progress", hs_n > 300, 1);
    chk("rnd_uc_served", uc_n > 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
